relay_contact_monitor: RTL and testbench

- Reader side of the HL-52S relay path. The relay block drives the coil; this block senses the relay's auxiliary/NO contact feedback and checks that the contact follows the coil command.
- Synchronises and debounces the raw contact line, and times the actuation after each command change.
- Latches a fault when the contact fails to follow the command or changes without a command.
- Sits beside the relay instance in relay_top:
  - Cmd_i is taken from the relay command (relay_w).
  - Contact_i comes from an FPGA pin.

---
 rtl/relay_contact_monitor_pkg.sv | 23 ++
 rtl/relay_debounce.sv | 45 ++++
 rtl/relay_contact_monitor.sv | 121 ++++++++++++
 tb/tb_relay_contact_monitor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/relay_contact_monitor_pkg.sv
// Shared state encodings, fault codes and default timing for the HL-52S relay contact monitor.
package relay_contact_monitor_pkg;

  typedef enum logic [1:0] {
    S_MATCH  = 2'd0,
    S_SETTLE = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_UNCMD   = 2'b10;

  // 10 ms debounce and 20 ms settle window at a 50 MHz system clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_SETTLE_CYCLES   = 1000000;
  localparam int DEFAULT_CNT_W           = 21;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relay_debounce.sv
// Two-flop synchroniser and stability counter for the raw relay contact feedback line.
module relay_debounce
  import relay_contact_monitor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic contact_raw,
  output logic contact_deb
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] deb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= contact_raw;
      sync_2 <= sync_1;
    end
  end

  // Any sample agreeing with the accepted level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt     <= '0;
      contact_deb <= 1'b0;
    end else if (sync_2 == contact_deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt     <= '0;
      contact_deb <= sync_2;
    end else begin
      deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/relay_contact_monitor.sv
// Checks that the debounced HL-52S contact follows the coil command and latches a fault otherwise.
// Optional RELAY_FAULT_COUNT_EN adds FaultCnt_o, a saturating count of fault entries.
module relay_contact_monitor
  import relay_contact_monitor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SETTLE_CYCLES   = DEFAULT_SETTLE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic       Cmd_i,
  input  logic       Contact_i,
  input  logic       Clear_i,
  output logic       Contact_o,
  output logic       Settling_o,
  output logic       Fault_o,
  output logic [1:0] FaultCode_o
`ifdef RELAY_FAULT_COUNT_EN
  ,
  output logic [7:0] FaultCnt_o
`endif
);

  if ((longint'(1) << CNT_W) <= longint'(max_int(DEBOUNCE_CYCLES, SETTLE_CYCLES))) begin : g_cnt_w_check
    $error("relay_contact_monitor: CNT_W too narrow for DEBOUNCE_CYCLES/SETTLE_CYCLES");
  end

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] next_timer;
  logic [1:0]       next_code;
  logic             cmd_q;
  logic             cmd_edge;
  logic             matched;

  relay_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk         (Clk_i),
    .rst_n       (Reset_i),
    .contact_raw (Contact_i),
    .contact_deb (Contact_o)
  );

  assign cmd_edge = Cmd_i ^ cmd_q;
  assign matched  = (Contact_o == Cmd_i);

  // A match on the timeout cycle takes priority, so a late-but-valid contact never faults.
  always_comb begin
    next_state = state;
    next_timer = '0;
    next_code  = FaultCode_o;
    case (state)
      S_MATCH: begin
        if (cmd_edge) begin
          next_state = S_SETTLE;
        end else if (!matched) begin
          next_state = S_FAULT;
          next_code  = FC_UNCMD;
        end
      end
      S_SETTLE: begin
        if (matched) begin
          next_state = S_MATCH;
        end else if (cmd_edge) begin
          next_timer = '0;
        end else if (timer == SETTLE_LAST) begin
          next_state = S_FAULT;
          next_code  = FC_TIMEOUT;
        end else begin
          next_timer = timer + CNT_W'(1);
        end
      end
      S_FAULT: begin
        if (Clear_i && matched) begin
          next_state = S_MATCH;
          next_code  = FC_NONE;
        end
      end
      default: begin
        next_state = S_MATCH;
        next_code  = FC_NONE;
      end
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state       <= S_MATCH;
      timer       <= '0;
      cmd_q       <= 1'b0;
      Settling_o  <= 1'b0;
      Fault_o     <= 1'b0;
      FaultCode_o <= FC_NONE;
    end else begin
      state       <= next_state;
      timer       <= next_timer;
      cmd_q       <= Cmd_i;
      Settling_o  <= (next_state == S_SETTLE);
      Fault_o     <= (next_state == S_FAULT);
      FaultCode_o <= next_code;
    end
  end

`ifdef RELAY_FAULT_COUNT_EN
  // Counts entries rather than cycles spent faulted; survives Clear_i.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      FaultCnt_o <= 8'd0;
    end else if ((next_state == S_FAULT) && (state != S_FAULT) && (FaultCnt_o != 8'hFF)) begin
      FaultCnt_o <= FaultCnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_relay_contact_monitor.sv
// Directed self-checking bench for relay_contact_monitor with short debounce/settle windows.
module tb_relay_contact_monitor;

  localparam int DEB = 4;
  localparam int SET = 16;
  localparam int CW  = 5;

  typedef struct {
    logic       cmd;
    logic       contact;
    logic       clear;
    logic       exp_contact;
    logic       exp_settling;
    logic       exp_fault;
    logic [1:0] exp_code;
  } vec_t;

  logic       Clk_i     = 1'b0;
  logic       Reset_i   = 1'b0;
  logic       Cmd_i     = 1'b0;
  logic       Contact_i = 1'b0;
  logic       Clear_i   = 1'b0;
  logic       Contact_o;
  logic       Settling_o;
  logic       Fault_o;
  logic [1:0] FaultCode_o;
`ifdef RELAY_FAULT_COUNT_EN
  logic [7:0] FaultCnt_o;
`endif

  int   compared   = 0;
  int   mismatched = 0;
  vec_t vecs[$];

  relay_contact_monitor #(
    .DEBOUNCE_CYCLES (DEB),
    .SETTLE_CYCLES   (SET),
    .CNT_W           (CW)
  ) dut (
    .Clk_i       (Clk_i),
    .Reset_i     (Reset_i),
    .Cmd_i       (Cmd_i),
    .Contact_i   (Contact_i),
    .Clear_i     (Clear_i),
    .Contact_o   (Contact_o),
    .Settling_o  (Settling_o),
    .Fault_o     (Fault_o),
    .FaultCode_o (FaultCode_o)
`ifdef RELAY_FAULT_COUNT_EN
    ,
    .FaultCnt_o  (FaultCnt_o)
`endif
  );

  always #5 Clk_i = ~Clk_i;

  task automatic tick();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic cmd, input logic contact, input logic clear);
    Cmd_i     = cmd;
    Contact_i = contact;
    Clear_i   = clear;
  endtask

  task automatic addVec(input logic cmd, input logic contact, input logic clear,
                        input logic ec, input logic es, input logic ef, input logic [1:0] code);
    vec_t v;
    v.cmd          = cmd;
    v.contact      = contact;
    v.clear        = clear;
    v.exp_contact  = ec;
    v.exp_settling = es;
    v.exp_fault    = ef;
    v.exp_code     = code;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic ec, input logic es,
                             input logic ef, input logic [1:0] code);
    compared++;
    if ({Contact_o, Settling_o, Fault_o, FaultCode_o} !== {ec, es, ef, code}) begin
      mismatched++;
      $display("[TB] FAIL %s: got contact=%b settling=%b fault=%b code=%b, expected contact=%b settling=%b fault=%b code=%b",
               name, Contact_o, Settling_o, Fault_o, FaultCode_o, ec, es, ef, code);
    end
  endtask

`ifdef RELAY_FAULT_COUNT_EN
  task automatic checkCount(input string name, input logic [7:0] exp_cnt);
    compared++;
    if (FaultCnt_o !== exp_cnt) begin
      mismatched++;
      $display("[TB] FAIL %s: got count=%0d, expected count=%0d", name, FaultCnt_o, exp_cnt);
    end
  endtask
`endif

  initial begin
    // Follow: contact rises 3 cycles after the command, Clear_i pulses while settling/matched are ignored.
    addVec(1, 0, 0, 0, 1, 0, 2'b00);
    addVec(1, 0, 0, 0, 1, 0, 2'b00);
    addVec(1, 0, 1, 0, 1, 0, 2'b00);
    for (int i = 0; i < 5; i++) addVec(1, 1, 0, 0, 1, 0, 2'b00);
    addVec(1, 1, 0, 1, 1, 0, 2'b00);
    addVec(1, 1, 0, 1, 0, 0, 2'b00);
    addVec(1, 1, 1, 1, 0, 0, 2'b00);
    addVec(0, 0, 0, 1, 1, 0, 2'b00);
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 1, 1, 0, 2'b00);
    addVec(0, 0, 0, 0, 1, 0, 2'b00);
    addVec(0, 0, 0, 0, 0, 0, 2'b00);
    addVec(0, 0, 0, 0, 0, 0, 2'b00);
    // Bounce every 2 cycles, then runs of 3 that just miss the debounce window.
    for (int i = 0; i < 12; i++) addVec(0, ((i / 2) % 2) == 0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 8; i++) addVec(0, (i % 4) != 3, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 0, 0, 0, 2'b00);

    applyStimulus(0, 0, 0);
    repeat (3) tick();
    checkOutput("reset_state", 0, 0, 0, 2'b00);
    Reset_i = 1'b1;
    tick();
    checkOutput("idle_after_reset", 0, 0, 0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].contact, vecs[i].clear);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_contact, vecs[i].exp_settling,
                  vecs[i].exp_fault, vecs[i].exp_code);
    end

    // Contact arrives on exactly the timeout cycle: the match wins.
    applyStimulus(1, 0, 0);
    for (int n = 1; n <= 17; n++) begin
      if (n == 11) applyStimulus(1, 1, 0);
      tick();
      checkOutput($sformatf("expiry_e%0d", n), n >= 16, n <= 16, 1'b0, 2'b00);
    end
    applyStimulus(0, 0, 0);
    repeat (7) tick();
    checkOutput("expiry_return", 0, 0, 0, 2'b00);

    // Fail-to-follow timeout, ignored clear while mismatched, then recovery.
    applyStimulus(1, 0, 0);
    for (int n = 1; n <= 17; n++) begin
      tick();
      checkOutput($sformatf("timeout_e%0d", n), 1'b0, n <= 16, n == 17, (n == 17) ? 2'b01 : 2'b00);
    end
    applyStimulus(1, 0, 1);
    tick();
    checkOutput("timeout_clear_ignored", 0, 0, 1, 2'b01);
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("timeout_cmd_drop", 0, 0, 1, 2'b01);
    applyStimulus(0, 0, 1);
    tick();
    checkOutput("timeout_cleared", 0, 0, 0, 2'b00);
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("timeout_idle", 0, 0, 0, 2'b00);

    // Uncommanded closure held for 10 cycles.
    applyStimulus(0, 1, 0);
    for (int n = 1; n <= 7; n++) begin
      tick();
      checkOutput($sformatf("uncmd_e%0d", n), n >= 6, 1'b0, n == 7, (n == 7) ? 2'b10 : 2'b00);
    end
    applyStimulus(0, 1, 1);
    tick();
    checkOutput("uncmd_clear_ignored", 1, 0, 1, 2'b10);
    applyStimulus(0, 1, 0);
    repeat (2) tick();
    applyStimulus(0, 0, 0);
    repeat (6) tick();
    checkOutput("uncmd_contact_back", 0, 0, 1, 2'b10);
    applyStimulus(0, 0, 1);
    tick();
    checkOutput("uncmd_cleared", 0, 0, 0, 2'b00);
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("uncmd_idle", 0, 0, 0, 2'b00);

    // Reset asserted mid-settle with the timer at 8.
    applyStimulus(1, 0, 0);
    repeat (9) tick();
    checkOutput("pre_reset_settle", 0, 1, 0, 2'b00);
    Reset_i = 1'b0;
    #1;
    checkOutput("reset_async", 0, 0, 0, 2'b00);
    tick();
    checkOutput("reset_held", 0, 0, 0, 2'b00);
    Reset_i = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      tick();
      checkOutput($sformatf("post_reset_e%0d", n), 1'b0, n <= 16, n == 17, (n == 17) ? 2'b01 : 2'b00);
    end
    applyStimulus(0, 0, 0);
    tick();
    applyStimulus(0, 0, 1);
    tick();
    applyStimulus(0, 0, 0);
    checkOutput("post_reset_cleared", 0, 0, 0, 2'b00);

`ifdef RELAY_FAULT_COUNT_EN
    checkCount("faultcnt_after_reset", 8'd1);
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1, 0, 0);
      repeat (17) tick();
      checkOutput("cnt_loop_fault", 0, 0, 1, 2'b01);
      applyStimulus(0, 0, 0);
      tick();
      applyStimulus(0, 0, 1);
      tick();
      applyStimulus(0, 0, 0);
      checkOutput("cnt_loop_cleared", 0, 0, 0, 2'b00);
      if (k == 99) checkCount("faultcnt_mid", 8'd101);
    end
    checkCount("faultcnt_saturated", 8'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
